// File: rtl/idli_sqi_ctrl_m_pkg.sv
// Shared types and constants for the SQI memory controller.
// Command, address-phase and nibble-length definitions live here.
package idli_sqi_ctrl_m_pkg;

    typedef enum logic {
        SQI_MODE_IN  = 1'b0,
        SQI_MODE_OUT = 1'b1
    } sqi_io_mode_t;

    typedef enum logic [2:0] {
        SQI_ST_IDLE,
        SQI_ST_CMD,
        SQI_ST_ADDR,
        SQI_ST_DUMMY,
        SQI_ST_DATA,
        SQI_ST_DONE
    } sqi_state_t;

    localparam logic [7:0] SQI_CMD_READ  = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

    localparam logic [3:0] SQI_LEN_CMD   = 4'd2;
    localparam logic [3:0] SQI_LEN_ADDR  = 4'd6;
    localparam logic [3:0] SQI_LEN_DUMMY = 4'd2;
    localparam logic [3:0] SQI_LEN_DATA  = 4'd4;

    // Word address to 24-bit byte address sent on the bus.
    function automatic logic [23:0] sqi_byte_addr(input logic [15:0] word_addr);
        return {7'b0, word_addr, 1'b0};
    endfunction

endpackage

// File: rtl/idli_sqi_ctrl_m.sv
// SQI (quad-SPI) memory controller: one 16-bit word per request, read or write.
// Frame is CMD(2) ADDR(6) [DUMMY(2)] DATA(4) nibbles, followed by one DONE cycle.
module idli_sqi_ctrl_m
    import idli_sqi_ctrl_m_pkg::*;
(
    input  logic         i_sqi_gck,
    input  logic         i_sqi_rst_n,
    input  logic         i_sqi_req_vld,
    output logic         o_sqi_req_acp,
    input  logic         i_sqi_req_wr,
    input  logic [15:0]  i_sqi_req_addr,
    input  logic [15:0]  i_sqi_req_data,
    output logic         o_sqi_rsp_vld,
    output logic [15:0]  o_sqi_rsp_data,
    output logic         o_sqi_mem_sck,
    output logic         o_sqi_mem_cs,
    output sqi_io_mode_t o_sqi_mem_io_mode,
    input  logic [3:0]   i_sqi_mem_sio,
    output logic [3:0]   o_sqi_mem_sio
);

    sqi_state_t   state_q;
    logic [3:0]   cnt_q;
    logic         wr_q;
    logic [3:0]   cmd_lo_q;
    logic [23:0]  ac_q;
    logic [15:0]  wdat_q;
    logic [15:0]  rdat_q;
    logic         acp_q;
    logic         cs_q;
    sqi_io_mode_t mode_q;
    logic [3:0]   sio_q;
    logic         rsp_vld_q;
    logic [15:0]  rsp_data_q;
    logic [7:0]   cmd_w;

    always_comb begin
        cmd_w = i_sqi_req_wr ? SQI_CMD_WRITE : SQI_CMD_READ;
    end

    // Outputs are registered alongside the state they belong to, so each
    // output reflects the state it was loaded with on the same edge.
    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state_q    <= SQI_ST_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            cmd_lo_q   <= '0;
            ac_q       <= '0;
            wdat_q     <= '0;
            rdat_q     <= '0;
            acp_q      <= 1'b1;
            cs_q       <= 1'b1;
            mode_q     <= SQI_MODE_OUT;
            sio_q      <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            rsp_vld_q <= 1'b0;
            unique case (state_q)
                SQI_ST_IDLE: begin
                    if (i_sqi_req_vld && acp_q) begin
                        state_q  <= SQI_ST_CMD;
                        cnt_q    <= SQI_LEN_CMD - 4'd1;
                        wr_q     <= i_sqi_req_wr;
                        cmd_lo_q <= cmd_w[3:0];
                        ac_q     <= sqi_byte_addr(i_sqi_req_addr);
                        wdat_q   <= i_sqi_req_data;
                        acp_q    <= 1'b0;
                        cs_q     <= 1'b0;
                        sio_q    <= cmd_w[7:4];
                    end
                end
                SQI_ST_CMD: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                        sio_q <= cmd_lo_q;
                    end else begin
                        state_q <= SQI_ST_ADDR;
                        cnt_q   <= SQI_LEN_ADDR - 4'd1;
                        sio_q   <= ac_q[23:20];
                        ac_q    <= ac_q << 4;
                    end
                end
                SQI_ST_ADDR: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                        sio_q <= ac_q[23:20];
                        ac_q  <= ac_q << 4;
                    end else if (wr_q) begin
                        state_q <= SQI_ST_DATA;
                        cnt_q   <= SQI_LEN_DATA - 4'd1;
                        sio_q   <= wdat_q[15:12];
                        wdat_q  <= wdat_q << 4;
                    end else begin
                        state_q <= SQI_ST_DUMMY;
                        cnt_q   <= SQI_LEN_DUMMY - 4'd1;
                        mode_q  <= SQI_MODE_IN;
                        sio_q   <= '0;
                    end
                end
                SQI_ST_DUMMY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= SQI_ST_DATA;
                        cnt_q   <= SQI_LEN_DATA - 4'd1;
                    end
                end
                SQI_ST_DATA: begin
                    if (!wr_q) begin
                        rdat_q <= {rdat_q[11:0], i_sqi_mem_sio};
                    end
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (wr_q) begin
                            sio_q  <= wdat_q[15:12];
                            wdat_q <= wdat_q << 4;
                        end
                    end else begin
                        state_q   <= SQI_ST_DONE;
                        cnt_q     <= '0;
                        cs_q      <= 1'b1;
                        mode_q    <= SQI_MODE_OUT;
                        sio_q     <= '0;
                        rsp_vld_q <= 1'b1;
                        if (!wr_q) begin
                            rsp_data_q <= {rdat_q[11:0], i_sqi_mem_sio};
                        end
                    end
                end
                SQI_ST_DONE: begin
                    state_q <= SQI_ST_IDLE;
                    acp_q   <= 1'b1;
                end
                default: begin
                    state_q <= SQI_ST_IDLE;
                    cnt_q   <= '0;
                    acp_q   <= 1'b1;
                    cs_q    <= 1'b1;
                    mode_q  <= SQI_MODE_OUT;
                    sio_q   <= '0;
                end
            endcase
        end
    end

    assign o_sqi_mem_sck     = i_sqi_gck;
    assign o_sqi_req_acp     = acp_q;
    assign o_sqi_rsp_vld     = rsp_vld_q;
    assign o_sqi_rsp_data    = rsp_data_q;
    assign o_sqi_mem_cs      = cs_q;
    assign o_sqi_mem_io_mode = mode_q;
    assign o_sqi_mem_sio     = sio_q;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed bench for idli_sqi_ctrl_m: checks each bus cycle of a frame against
// hand-written nibble sequences, plus back-to-back, write-after-read and reset abort.
module tb_idli_sqi_ctrl_m;
    import idli_sqi_ctrl_m_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         req_vld;
    logic         req_acp;
    logic         req_wr;
    logic [15:0]  req_addr;
    logic [15:0]  req_data;
    logic         rsp_vld;
    logic [15:0]  rsp_data;
    logic         mem_sck;
    logic         mem_cs;
    sqi_io_mode_t mem_mode;
    logic [3:0]   mem_sio_in;
    logic [3:0]   mem_sio_out;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned acc_cnt = 0;
    int unsigned hi_run = 0;
    int unsigned last_gap = 0;

    idli_sqi_ctrl_m u_dut (
        .i_sqi_gck         (clk),
        .i_sqi_rst_n       (rst_n),
        .i_sqi_req_vld     (req_vld),
        .o_sqi_req_acp     (req_acp),
        .i_sqi_req_wr      (req_wr),
        .i_sqi_req_addr    (req_addr),
        .i_sqi_req_data    (req_data),
        .o_sqi_rsp_vld     (rsp_vld),
        .o_sqi_rsp_data    (rsp_data),
        .o_sqi_mem_sck     (mem_sck),
        .o_sqi_mem_cs      (mem_cs),
        .o_sqi_mem_io_mode (mem_mode),
        .i_sqi_mem_sio     (mem_sio_in),
        .o_sqi_mem_sio     (mem_sio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && req_vld && req_acp) acc_cnt++;
    end

    // Length of the most recent run of CS-high samples that ended in a CS fall.
    always @(negedge clk) begin
        if (mem_cs) begin
            hi_run++;
        end else begin
            if (hi_run != 0) last_gap = hi_run;
            hi_run = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // exp_sio: 14 nibbles, first bus nibble in bits [55:52]; zeros where SIO must idle.
    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] mem, input logic [55:0] exp_sio,
                           input logic [15:0] exp_rsp, input logic hold);
        int unsigned len;
        logic [3:0]  nib;
        len      = wr ? 12 : 14;
        req_vld  = 1'b1;
        req_wr   = wr;
        req_addr = addr;
        req_data = wdata;
        for (int i = 0; i < 40 && !req_acp; i++) @(negedge clk);
        check_eq("acp_wait", {31'b0, req_acp}, 32'd1);
        for (int k = 0; k < int'(len); k++) begin
            @(negedge clk);
            if (k == 0 && !hold) req_vld = 1'b0;
            nib = exp_sio[55 - 4*k -: 4];
            check_eq($sformatf("cs_k%0d", k), {31'b0, mem_cs}, 32'd0);
            check_eq($sformatf("acp_k%0d", k), {31'b0, req_acp}, 32'd0);
            check_eq($sformatf("vld_k%0d", k), {31'b0, rsp_vld}, 32'd0);
            check_eq($sformatf("mode_k%0d", k), {31'b0, mem_mode}, (wr || k < 8) ? 32'd1 : 32'd0);
            check_eq($sformatf("sio_k%0d", k), {28'b0, mem_sio_out}, {28'b0, nib});
            mem_sio_in = (!wr && k >= 10) ? mem[15 - 4*(k-10) -: 4] : 4'h9;
        end
        @(negedge clk);
        mem_sio_in = 4'h9;
        check_eq("done_cs", {31'b0, mem_cs}, 32'd1);
        check_eq("done_vld", {31'b0, rsp_vld}, 32'd1);
        check_eq("done_acp", {31'b0, req_acp}, 32'd0);
        check_eq("done_mode", {31'b0, mem_mode}, 32'd1);
        check_eq("done_sio", {28'b0, mem_sio_out}, 32'd0);
        check_eq("done_rsp", {16'b0, rsp_data}, {16'b0, exp_rsp});
        @(negedge clk);
        check_eq("idle_acp", {31'b0, req_acp}, 32'd1);
        check_eq("idle_vld", {31'b0, rsp_vld}, 32'd0);
        check_eq("idle_cs", {31'b0, mem_cs}, 32'd1);
    endtask

    initial begin
        int unsigned acc0;
        logic        vld_seen;
        logic        cs_low_seen;
        rst_n      = 1'b0;
        req_vld    = 1'b0;
        req_wr     = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        mem_sio_in = 4'h9;
        repeat (3) @(negedge clk);
        check_eq("rst_cs", {31'b0, mem_cs}, 32'd1);
        check_eq("rst_mode", {31'b0, mem_mode}, 32'd1);
        check_eq("rst_sio", {28'b0, mem_sio_out}, 32'd0);
        check_eq("rst_vld", {31'b0, rsp_vld}, 32'd0);
        check_eq("rst_rsp", {16'b0, rsp_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_acp", {31'b0, req_acp}, 32'd1);
        check_eq("sck_follows_clk", {31'b0, mem_sck}, {31'b0, clk});

        // Write 0x1234 <- 0xBEEF: cmd 0,2 / addr 0x002468 / data B,E,E,F
        run_txn(1'b1, 16'h1234, 16'hBEEF, 16'h0000, 56'h02002468BEEF00, 16'h0000, 1'b0);
        // Read 0x0001, memory returns A5C3: cmd 0,3 / addr 0x000002
        run_txn(1'b0, 16'h0001, 16'h0000, 16'hA5C3, 56'h03000002000000, 16'hA5C3, 1'b0);
        // Write after read at top address: addr nibbles 0,1,F,F,F,E; rsp_data keeps A5C3
        run_txn(1'b1, 16'hFFFF, 16'h1357, 16'h0000, 56'h0201FFFE135700, 16'hA5C3, 1'b0);
        run_txn(1'b0, 16'hFFFF, 16'h0000, 16'h7E81, 56'h0301FFFE000000, 16'h7E81, 1'b0);

        // Two writes with req_vld held throughout
        acc0 = acc_cnt;
        run_txn(1'b1, 16'h0010, 16'h0F0F, 16'h0000, 56'h020000200F0F00, 16'h7E81, 1'b1);
        run_txn(1'b1, 16'h8000, 16'hFFFF, 16'h0000, 56'h02010000FFFF00, 16'h7E81, 1'b0);
        check_eq("b2b_accepts", acc_cnt - acc0, 32'd2);
        // The CS-high gap spans DONE plus the single IDLE cycle where the accept lands
        check_eq("b2b_cs_gap", last_gap, 32'd2);

        // Read aborted by reset during the address phase
        req_vld  = 1'b1;
        req_wr   = 1'b0;
        req_addr = 16'h0ABC;
        for (int i = 0; i < 40 && !req_acp; i++) @(negedge clk);
        check_eq("abort_acp_wait", {31'b0, req_acp}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) req_vld = 1'b0;
        end
        check_eq("abort_pre_cs", {31'b0, mem_cs}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_cs", {31'b0, mem_cs}, 32'd1);
        check_eq("abort_mode", {31'b0, mem_mode}, 32'd1);
        check_eq("abort_sio", {28'b0, mem_sio_out}, 32'd0);
        check_eq("abort_vld", {31'b0, rsp_vld}, 32'd0);
        check_eq("abort_rsp", {16'b0, rsp_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vld_seen    = 1'b0;
        cs_low_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_vld) vld_seen = 1'b1;
            if (!mem_cs) cs_low_seen = 1'b1;
        end
        check_eq("abort_no_vld", {31'b0, vld_seen}, 32'd0);
        check_eq("abort_cs_idle", {31'b0, cs_low_seen}, 32'd0);
        check_eq("abort_acp", {31'b0, req_acp}, 32'd1);
        run_txn(1'b0, 16'h0ABC, 16'h0000, 16'h1234, 56'h03001578000000, 16'h1234, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
